// File: rtl/my_sync_bridge_interface.sv
// AHB-to-APB bridge sharing a single clock: one AHB slave port fronting one APB completer.
// Reads take SETUP/ACCESS directly; writes spend one WWAIT cycle collecting the AHB data phase.
module my_sync_bridge_interface #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hsel,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [DATA_W-1:0] hwdata,
    input  logic              hready,
    output logic              hreadyout,
    output logic              hresp,
    output logic [DATA_W-1:0] hrdata,
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic              psel,
    output logic              penable,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    typedef enum logic [2:0] {
        IDLE,
        WWAIT,
        SETUP,
        ACCESS,
        ERR2
    } state_t;

    state_t state;
    logic   accept;
    logic   take;
    logic   unused_ok;

    // Transfer size and the SEQ/NONSEQ distinction carry no meaning here.
    assign unused_ok = ^{hsize, htrans[0]};

    assign accept = hsel && htrans[1] && hready;

    always_comb begin
        hreadyout = 1'b0;
        hresp     = 1'b0;
        hrdata    = '0;
        case (state)
            IDLE: hreadyout = 1'b1;
            ERR2: begin
                hreadyout = 1'b1;
                hresp     = 1'b1;
            end
            ACCESS: begin
                hrdata = prdata;
                if (pready) begin
                    hreadyout = !pslverr;
                    hresp     = pslverr;
                end
            end
            default: ;
        endcase
    end

    // A new transfer may only start on a cycle where this slave signals ready.
    assign take = accept && hreadyout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            psel    <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            paddr   <= '0;
            pwdata  <= '0;
        end else begin
            case (state)
                WWAIT: begin
                    pwdata  <= hwdata;
                    state   <= SETUP;
                    psel    <= 1'b1;
                    penable <= 1'b0;
                end
                SETUP: begin
                    state   <= ACCESS;
                    penable <= 1'b1;
                end
                ACCESS: begin
                    if (pready) begin
                        state   <= pslverr ? ERR2 : IDLE;
                        psel    <= 1'b0;
                        penable <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    psel    <= 1'b0;
                    penable <= 1'b0;
                end
            endcase
            // Overrides the return-to-IDLE above so a pipelined transfer starts at once.
            if (take) begin
                paddr   <= haddr;
                pwrite  <= hwrite;
                state   <= hwrite ? WWAIT : SETUP;
                psel    <= !hwrite;
                penable <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_my_sync_bridge_interface.sv
// Directed bench for my_sync_bridge_interface: reads, writes, APB wait states,
// error response, pipelined transfers and mid-transfer reset.
module tb_my_sync_bridge_interface;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;
    logic [31:0] paddr;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    // Single-slave system: the bus ready is this slave's ready.
    assign hready = hreadyout;

    my_sync_bridge_interface #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .hsel      (hsel),
        .haddr     (haddr),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hwdata    (hwdata),
        .hready    (hready),
        .hreadyout (hreadyout),
        .hresp     (hresp),
        .hrdata    (hrdata),
        .paddr     (paddr),
        .pwrite    (pwrite),
        .psel      (psel),
        .penable   (penable),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ahb_idle();
        hsel   = 1'b0;
        htrans = 2'b00;
    endtask

    task automatic ahb_req(input logic [31:0] a, input logic w);
        hsel   = 1'b1;
        htrans = 2'b10;
        haddr  = a;
        hwrite = w;
    endtask

    initial begin
        rst = 1'b1; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
        hsize = 3'b010; hwdata = '0; prdata = '0; pready = 1'b1; pslverr = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_psel",    {31'd0, psel},      32'd0);
        check("rst_penable", {31'd0, penable},   32'd0);
        check("rst_pwrite",  {31'd0, pwrite},    32'd0);
        check("rst_paddr",   paddr,              32'd0);
        check("rst_pwdata",  pwdata,             32'd0);
        check("rst_hready",  {31'd0, hreadyout}, 32'd1);
        check("rst_hresp",   {31'd0, hresp},     32'd0);
        check("rst_hrdata",  hrdata,             32'd0);

        // Zero-wait read
        prdata = 32'hDEADBEEF;
        ahb_req(32'h1000, 1'b0);
        tick();                        // cycle 1
        ahb_idle();
        #1;
        check("rd_c1_psel",    {31'd0, psel},      32'd1);
        check("rd_c1_penable", {31'd0, penable},   32'd0);
        check("rd_c1_paddr",   paddr,              32'h1000);
        check("rd_c1_hready",  {31'd0, hreadyout}, 32'd0);
        check("rd_c1_hrdata",  hrdata,             32'd0);
        tick();                        // cycle 2
        check("rd_c2_psel",    {31'd0, psel},      32'd1);
        check("rd_c2_penable", {31'd0, penable},   32'd1);
        check("rd_c2_hready",  {31'd0, hreadyout}, 32'd1);
        check("rd_c2_hrdata",  hrdata,             32'hDEADBEEF);
        check("rd_c2_hresp",   {31'd0, hresp},     32'd0);
        tick();
        check("rd_c3_psel",    {31'd0, psel},      32'd0);
        check("rd_c3_hrdata",  hrdata,             32'd0);

        // Zero-wait write
        ahb_req(32'h2004, 1'b1);
        tick();                        // cycle 1: WWAIT
        ahb_idle();
        hwdata = 32'hA5A5A5A5;
        #1;
        check("wr_c1_psel",    {31'd0, psel},      32'd0);
        check("wr_c1_hready",  {31'd0, hreadyout}, 32'd0);
        tick();                        // cycle 2: SETUP
        hwdata = 32'h0;
        check("wr_c2_psel",    {31'd0, psel},      32'd1);
        check("wr_c2_penable", {31'd0, penable},   32'd0);
        check("wr_c2_pwrite",  {31'd0, pwrite},    32'd1);
        check("wr_c2_paddr",   paddr,              32'h2004);
        check("wr_c2_pwdata",  pwdata,             32'hA5A5A5A5);
        check("wr_c2_hready",  {31'd0, hreadyout}, 32'd0);
        tick();                        // cycle 3: ACCESS
        check("wr_c3_penable", {31'd0, penable},   32'd1);
        check("wr_c3_hready",  {31'd0, hreadyout}, 32'd1);
        tick();
        check("wr_c4_psel",    {31'd0, psel},      32'd0);

        // Read with three APB wait states
        pready = 1'b0;
        prdata = 32'h12345678;
        ahb_req(32'h3000, 1'b0);
        tick();
        ahb_idle();
        tick();
        for (int i = 0; i < 3; i++) begin
            check("ws_hready",  {31'd0, hreadyout}, 32'd0);
            check("ws_psel",    {31'd0, psel},      32'd1);
            check("ws_penable", {31'd0, penable},   32'd1);
            tick();
        end
        pready = 1'b1;
        #1;
        check("ws_a4_hready",  {31'd0, hreadyout}, 32'd1);
        check("ws_a4_penable", {31'd0, penable},   32'd1);
        check("ws_a4_hrdata",  hrdata,             32'h12345678);
        tick();
        check("ws_end_psel",   {31'd0, psel},      32'd0);

        // Write with slave error
        pslverr = 1'b1;
        ahb_req(32'h4000, 1'b1);
        tick();
        ahb_idle();
        tick();
        tick();                        // ACCESS with error
        check("err_a_hresp",   {31'd0, hresp},     32'd1);
        check("err_a_hready",  {31'd0, hreadyout}, 32'd0);
        tick();                        // ERR2
        pslverr = 1'b0;
        #1;
        check("err_b_hresp",   {31'd0, hresp},     32'd1);
        check("err_b_hready",  {31'd0, hreadyout}, 32'd1);
        check("err_b_psel",    {31'd0, psel},      32'd0);
        check("err_b_penable", {31'd0, penable},   32'd0);
        tick();
        check("err_c_hresp",   {31'd0, hresp},     32'd0);
        check("err_c_hready",  {31'd0, hreadyout}, 32'd1);

        // Back-to-back NONSEQ then SEQ read
        prdata = 32'hCAFE0001;
        ahb_req(32'h5000, 1'b0);
        tick();                        // SETUP #1; next address held while stalled
        htrans = 2'b11;
        haddr  = 32'h5004;
        tick();                        // ACCESS #1, accepts the SEQ
        check("b2b_a1_paddr",   paddr,              32'h5000);
        check("b2b_a1_penable", {31'd0, penable},   32'd1);
        check("b2b_a1_hready",  {31'd0, hreadyout}, 32'd1);
        tick();                        // SETUP #2
        ahb_idle();
        #1;
        check("b2b_s2_psel",    {31'd0, psel},      32'd1);
        check("b2b_s2_penable", {31'd0, penable},   32'd0);
        check("b2b_s2_paddr",   paddr,              32'h5004);
        tick();
        check("b2b_a2_penable", {31'd0, penable},   32'd1);
        check("b2b_a2_hrdata",  hrdata,             32'hCAFE0001);
        tick();
        check("b2b_end_psel",   {31'd0, psel},      32'd0);

        // Reset during ACCESS
        pready = 1'b0;
        ahb_req(32'h6000, 1'b0);
        tick();
        ahb_idle();
        tick();
        check("rsta_penable", {31'd0, penable}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pready = 1'b1;
        #1;
        check("rsta_psel",    {31'd0, psel},      32'd0);
        check("rsta_penable2",{31'd0, penable},   32'd0);
        check("rsta_hready",  {31'd0, hreadyout}, 32'd1);
        check("rsta_hresp",   {31'd0, hresp},     32'd0);

        // No APB activity for hsel=0, IDLE or BUSY
        hsel = 1'b0; htrans = 2'b10; haddr = 32'h7000;
        tick();
        check("nosel_psel",  {31'd0, psel}, 32'd0);
        hsel = 1'b1; htrans = 2'b00;
        tick();
        check("idle_psel",   {31'd0, psel}, 32'd0);
        htrans = 2'b01;
        tick();
        check("busy_psel",   {31'd0, psel}, 32'd0);
        check("busy_hready", {31'd0, hreadyout}, 32'd1);
        tick();
        check("busy_psel2",  {31'd0, psel}, 32'd0);
        check("busy_paddr",  paddr, 32'd0);
        ahb_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/my_sync_bridge_interface.md
MY_SYNC_BRIDGE_INTERFACE -- requirements
Module: my_sync_bridge_interface

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high.
REQ-002 SHALL have parameter ADDR_W, default 32, address width on both buses.
REQ-003 SHALL have parameter DATA_W, default 32, data width on both buses.
REQ-004 clk  in  1  bridge clock, rising-edge, shared by AHB and APB sides.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 hsel  in  1  AHB slave select.
REQ-007 haddr  in  ADDR_W  AHB address.
REQ-008 htrans  in  2  AHB transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-009 hwrite  in  1  1 = write.
REQ-010 hsize  in  3  accepted but ignored; all transfers are full-width.
REQ-011 hwdata  in  DATA_W  AHB write data, valid in the data phase.
REQ-012 hready  in  1  AHB bus ready; high means the previous transfer is complete.
REQ-013 hreadyout  out  1  slave ready.
REQ-014 hresp  out  1  0 OKAY, 1 ERROR.
REQ-015 hrdata  out  DATA_W  read data.
REQ-016 paddr, pwrite  out  ADDR_W, 1  APB address and direction, both registered.
REQ-017 psel, penable  out  1 each  APB select and enable, both registered.
REQ-018 pwdata  out  DATA_W  APB write data, registered.
REQ-019 prdata, pready, pslverr  in  DATA_W, 1, 1  APB completer response.

Function
REQ-020 Accept condition: hsel & htrans[1] & hready at a rising edge. On accept, haddr and hwrite SHALL be registered.
REQ-021 States: IDLE, WWAIT, SETUP, ACCESS, ERR2.
REQ-022 IDLE: accepted read -> SETUP; accepted write -> WWAIT; otherwise stay in IDLE. IDLE/BUSY transfers and hsel=0 SHALL get hreadyout=1, hresp=0 and produce no APB activity.
REQ-023 WWAIT: lasts 1 cycle, hreadyout=0, psel=0; hwdata SHALL be captured into pwdata at the end of the cycle; then -> SETUP.
REQ-024 SETUP: lasts 1 cycle; psel=1, penable=0, paddr/pwrite/pwdata stable, hreadyout=0; then -> ACCESS.
REQ-025 ACCESS: psel=1, penable=1.
- While pready=0: stay in ACCESS, hreadyout=0.
- Pready=1 with pslverr=0: hreadyout=1, hresp=0.
- Pready=1 with pslverr=1: hreadyout=0, hresp=1, next state ERR2.
REQ-026 ERR2: hreadyout=1, hresp=1, psel=0, penable=0 (second cycle of the two-cycle AHB ERROR response).
REQ-027 hrdata SHALL equal prdata combinationally during ACCESS; it is 0 in all other states.
REQ-028 hreadyout=1 in IDLE and ERR2, and in ACCESS when pready=1 and pslverr=0; 0 otherwise.
REQ-029 Pipelining: on leaving ACCESS (OKAY) or ERR2, a transfer accepted at the same edge SHALL go directly to SETUP (read) or WWAIT (write); otherwise -> IDLE.
REQ-030 Read latency: the address-phase edge counts as cycle 0; SETUP in cycle 1, ACCESS in cycle 2; with zero APB wait states, hreadyout=1 in cycle 2.
REQ-031 Write latency: WWAIT in cycle 1, SETUP in cycle 2, ACCESS in cycle 3; with zero APB wait states, hreadyout=1 in cycle 3.
REQ-032 psel SHALL drop (or a new SETUP SHALL begin) the cycle after pready; penable SHALL never be high for two consecutive transfers without an intervening SETUP.

Reset
REQ-033 When rst=1 at a rising edge, the next state SHALL be IDLE and outputs SHALL take their reset values: psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, hreadyout=1, hresp=0, hrdata=0.
REQ-034 Reset mid-transfer SHALL abort the APB access with no completion signalled on AHB.

Verification
REQ-035 Read, pready=1 always, prdata=0xDEADBEEF, haddr=0x1000 -> paddr=0x1000, psel in cycles 1-2, penable in cycle 2, hrdata=0xDEADBEEF with hreadyout=1 in cycle 2.
REQ-036 Write haddr=0x2004, hwdata=0xA5A5A5A5 -> WWAIT, SETUP with pwrite=1 and pwdata=0xA5A5A5A5, ACCESS; hreadyout=1 in cycle 3.
REQ-037 Read with pready low for 3 ACCESS cycles -> hreadyout stays 0 and psel/penable stay high for 4 ACCESS cycles; data is returned on the 4th.
REQ-038 Write with pslverr=1 -> hresp=1/hreadyout=0 for one cycle, then hresp=1/hreadyout=1 for one cycle, then IDLE.
REQ-039 Back-to-back NONSEQ read then SEQ read -> second SETUP immediately follows first ACCESS, no IDLE cycle.
REQ-040 rst asserted during ACCESS -> the next cycle shows psel=0, penable=0, hreadyout=1; htrans=IDLE or hsel=0 -> no APB activity.
